// File: rtl/int_arbiter.sv
// Interrupt arbiter: per-source edge detect into pending bits, software mask,
// lowest-index priority vector and an INT output with post-acknowledge holdoff.
module int_src_lane (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  input  logic clr_i,
  input  logic wr_mask_i,
  input  logic mask_bit_i,
  output logic pend_o,
  output logic mask_o
);
  logic irq_q, pend_q, mask_q;
  logic pend_d, mask_d;

  // A new edge beats a same-cycle clear so the event is never lost
  always_comb begin
    pend_d = (irq_i & ~irq_q) | (pend_q & ~clr_i);
    mask_d = wr_mask_i ? mask_bit_i : mask_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q  <= 1'b1;
      pend_q <= 1'b0;
      mask_q <= 1'b0;
    end else begin
      irq_q  <= irq_i;
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  assign pend_o = pend_q;
  assign mask_o = mask_q;
endmodule

module int_arbiter #(
  parameter int         N_SRC   = 8,
  parameter logic [7:0] MASK_ID = 8'h30,
  parameter logic [7:0] PEND_ID = 8'h31,
  parameter logic [7:0] VEC_ID  = 8'h32,
  parameter int         HOLDOFF = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic             INT,
  output logic [7:0]       RD_DATA,
  output logic             RD_HIT
);
  logic             ack, wr_mask;
  logic [N_SRC-1:0] clr, pend, mask, active;
  logic [3:0]       hold_q, hold_d;
  logic             int_q, int_d;
  logic [7:0]       vec;

  assign ack     = IO_STRB && (PORT_ID == PEND_ID);
  assign wr_mask = IO_STRB && (PORT_ID == MASK_ID);
  assign clr     = ack ? OUT_PORT[N_SRC-1:0] : '0;
  assign active  = pend & mask;

  for (genvar g = 0; g < N_SRC; g++) begin : g_lane
    int_src_lane u_lane (
      .clk_i      (CLK),
      .rst_i      (RESET),
      .irq_i      (IRQ[g]),
      .clr_i      (clr[g]),
      .wr_mask_i  (wr_mask),
      .mask_bit_i (OUT_PORT[g]),
      .pend_o     (pend[g]),
      .mask_o     (mask[g])
    );
  end

  // Holdoff keeps INT low long enough for the ISR's return to complete
  always_comb begin
    hold_d = hold_q;
    int_d  = |active;
    if (ack) begin
      hold_d = 4'(HOLDOFF);
      int_d  = 1'b0;
    end else if (hold_q != 4'd0) begin
      hold_d = hold_q - 4'd1;
      int_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hold_q <= 4'd0;
      int_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      int_q  <= int_d;
    end
  end

  assign INT = int_q;

  always_comb begin
    vec = 8'hFF;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (active[i]) vec = 8'(i);
  end

  always_comb begin
    RD_DATA = 8'h00;
    RD_HIT  = 1'b0;
    if (PORT_ID == MASK_ID) begin
      RD_DATA = 8'(mask);
      RD_HIT  = 1'b1;
    end else if (PORT_ID == PEND_ID) begin
      RD_DATA = 8'(pend);
      RD_HIT  = 1'b1;
    end else if (PORT_ID == VEC_ID) begin
      RD_DATA = vec;
      RD_HIT  = 1'b1;
    end
  end
endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: directed scenarios with literal expectations, then
// random traffic compared every cycle against a behavioural model.
module tb_int_arbiter;
  localparam int HOLDOFF = 2;

  logic       CLK, RESET, IO_STRB, INT, RD_HIT;
  logic [7:0] IRQ, PORT_ID, OUT_PORT, RD_DATA;

  int_arbiter #(.N_SRC(8), .MASK_ID(8'h30), .PEND_ID(8'h31), .VEC_ID(8'h32),
                .HOLDOFF(HOLDOFF)) dut (
    .CLK(CLK), .RESET(RESET), .IRQ(IRQ), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .INT(INT), .RD_DATA(RD_DATA), .RD_HIT(RD_HIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural model
  logic [7:0] m_pend, m_mask, m_irq;
  logic       m_int;
  int         m_hold;
  logic       is_ack, is_wm;
  assign is_ack = IO_STRB && (PORT_ID == 8'h31);
  assign is_wm  = IO_STRB && (PORT_ID == 8'h30);

  function automatic logic [7:0] next_pend(input logic [7:0] p, input logic [7:0] irq,
                                           input logic [7:0] prev, input logic ack,
                                           input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      if (irq[i] && !prev[i])  r[i] = 1'b1;
      else if (ack && d[i])    r[i] = 1'b0;
      else                     r[i] = p[i];
    end
    return r;
  endfunction

  function automatic logic [7:0] m_vec();
    for (int i = 0; i < 8; i++)
      if (m_pend[i] && m_mask[i]) return 8'(i);
    return 8'hFF;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [7:0] id);
    case (id)
      8'h30:   return m_mask;
      8'h31:   return m_pend;
      8'h32:   return m_vec();
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_pend <= 8'h00; m_mask <= 8'h00; m_irq <= 8'hFF; m_int <= 1'b0; m_hold <= 0;
    end else begin
      m_int  <= is_ack ? 1'b0 : (m_hold != 0) ? 1'b0 : ((m_pend & m_mask) != 8'h00);
      m_hold <= is_ack ? HOLDOFF : (m_hold > 0 ? m_hold - 1 : 0);
      m_pend <= next_pend(m_pend, IRQ, m_irq, is_ack, OUT_PORT);
      m_mask <= is_wm ? OUT_PORT : m_mask;
      m_irq  <= IRQ;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    PORT_ID = id; OUT_PORT = d; IO_STRB = 1'b1;
    tick();
    IO_STRB = 1'b0;
  endtask

  task automatic chk_rd(input string nm, input logic [7:0] id, input logic [7:0] exp);
    PORT_ID = id;
    #1;
    chk(nm, RD_DATA, exp);
  endtask

  initial begin
    RESET = 1'b1; IRQ = 8'h01; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0;

    // Every-cycle comparison against the model, away from the active edge
    fork
      forever begin
        @(negedge CLK);
        chk("cyc_int", 8'(INT), 8'(m_int));
        chk("cyc_rd",  RD_DATA, exp_rd(PORT_ID));
        chk("cyc_hit", 8'(RD_HIT), 8'((PORT_ID >= 8'h30) && (PORT_ID <= 8'h32)));
      end
    join_none

    // 1: line held high through reset does not trigger
    repeat (3) tick();
    chk("rst_int", 8'(INT), 8'h00);
    chk_rd("rst_vec", 8'h32, 8'hFF);
    RESET = 1'b0;
    tick();
    wr(8'h30, 8'hFF);
    tick(); tick();
    chk_rd("t1_pend0", 8'h31, 8'h00);
    chk("t1_int0", 8'(INT), 8'h00);
    IRQ = 8'h00; tick();
    IRQ = 8'h01; tick();
    chk_rd("t1_pend", 8'h31, 8'h01);
    chk("t1_model_pend", m_pend, 8'h01);
    chk("t1_int_lat", 8'(INT), 8'h00);
    tick();
    chk("t1_int1", 8'(INT), 8'h01);

    // 2: pending is independent of mask
    wr(8'h31, 8'hFF);
    wr(8'h30, 8'h00);
    IRQ = 8'h09; tick();
    IRQ = 8'h01; tick();
    chk_rd("t2_pend", 8'h31, 8'h08);
    chk("t2_int0", 8'(INT), 8'h00);
    wr(8'h30, 8'h08);
    chk("t2_int_w", 8'(INT), 8'h00);
    tick();
    chk("t2_int1", 8'(INT), 8'h01);
    chk_rd("t2_vec", 8'h32, 8'h03);

    // 3: simultaneous edges, priority, holdoff
    wr(8'h31, 8'hFF);
    wr(8'h30, 8'hFF);
    IRQ = 8'h24; tick();
    IRQ = 8'h00; tick();
    chk_rd("t3_vec", 8'h32, 8'h02);
    chk("t3_model_vec", m_vec(), 8'h02);
    tick(); tick();
    chk("t3_int1", 8'(INT), 8'h01);
    wr(8'h31, 8'h04);
    chk("t3_hold0", 8'(INT), 8'h00);
    tick(); chk("t3_hold1", 8'(INT), 8'h00);
    tick(); chk("t3_hold2", 8'(INT), 8'h00);
    tick(); chk("t3_rearm", 8'(INT), 8'h01);
    chk_rd("t3_vec5", 8'h32, 8'h05);

    // 4: set wins over same-cycle clear
    IRQ = 8'h02;
    wr(8'h31, 8'h02);
    chk_rd("t4_pend", 8'h31, 8'h22);
    chk("t4_int_a", 8'(INT), 8'h00);
    tick(); chk("t4_int_b", 8'(INT), 8'h00);
    tick(); chk("t4_int_c", 8'(INT), 8'h00);
    tick(); chk("t4_int_hi", 8'(INT), 8'h01);

    // 5: asynchronous reset mid-cycle
    wr(8'h31, 8'hFF);
    IRQ = 8'h00; tick();
    IRQ = 8'h81; tick();
    chk_rd("t5_pend", 8'h31, 8'h81);
    repeat (3) tick();
    chk("t5_int1", 8'(INT), 8'h01);
    #2 RESET = 1'b1;
    #1 chk("t5_rst_int", 8'(INT), 8'h00);
    chk_rd("t5_rst_pend", 8'h31, 8'h00);
    chk_rd("t5_rst_mask", 8'h30, 8'h00);
    chk_rd("t5_rst_vec", 8'h32, 8'hFF);
    chk("t5_model_pend", m_pend, 8'h00);
    tick();
    RESET = 1'b0;
    tick(); tick();
    chk_rd("t5_noretrig", 8'h31, 8'h00);

    // 6: foreign port ID write is ignored
    PORT_ID = 8'h40; OUT_PORT = 8'hFF; IO_STRB = 1'b1;
    #1 chk("t6_hit", 8'(RD_HIT), 8'h00);
    chk("t6_data", RD_DATA, 8'h00);
    tick();
    IO_STRB = 1'b0;
    chk_rd("t6_mask", 8'h30, 8'h00);
    chk_rd("t6_pend", 8'h31, 8'h00);
    wr(8'h32, 8'hFF);
    chk_rd("t6_vec", 8'h32, 8'hFF);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      RESET   = ($urandom_range(0, 299) == 0);
      IRQ     = IRQ ^ 8'($urandom & $urandom);
      IO_STRB = ($urandom_range(0, 3) == 0);
      OUT_PORT = 8'($urandom);
      case ($urandom_range(0, 4))
        0:       PORT_ID = 8'h30;
        1:       PORT_ID = 8'h31;
        2:       PORT_ID = 8'h32;
        3:       PORT_ID = 8'h40;
        default: PORT_ID = 8'($urandom);
      endcase
      tick();
    end
    RESET = 1'b0; IO_STRB = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
